// File: rtl/regfile_rn.sv
// Architectural register file with ROB-tag rename tracking, commit bypass and branch checkpoints.
// Reads are combinational; all state moves on the rising edge, and ready low holds everything except clear.
module regfile_rn #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int ROB_W   = 4,
  parameter int NRP     = 2,
  parameter int NCOMMIT = 2,
  parameter int NCKPT   = 4,
  localparam int REG_W  = $clog2(NREG),
  localparam int CK_W   = $clog2(NCKPT),
  localparam int CNT_W  = CK_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic                     clear,
  input  logic [NRP-1:0]           rd_query,
  input  logic [NRP*REG_W-1:0]     rd_pos,
  output logic [NRP-1:0]           rd_flag,
  output logic [NRP-1:0]           rd_type,
  output logic [NRP*XLEN-1:0]      rd_val,
  input  logic                     lock,
  input  logic [REG_W-1:0]         lock_rd,
  input  logic [ROB_W-1:0]         lock_robpos,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*REG_W-1:0] cm_rd,
  input  logic [NCOMMIT*ROB_W-1:0] cm_robpos,
  input  logic [NCOMMIT*XLEN-1:0]  cm_val,
  input  logic                     ckpt_save,
  output logic [CK_W-1:0]          ckpt_id,
  output logic                     ckpt_full,
  input  logic                     ckpt_release,
  input  logic                     ckpt_restore,
  input  logic [CK_W-1:0]          ckpt_restore_id
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [ROB_W-1:0] qi_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [ROB_W-1:0] snap_qi_q [NCKPT][NREG];
  logic [NREG-1:0]  snap_busy_q [NCKPT];
  logic [CK_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [REG_W-1:0] c_rd  [NCOMMIT];
  logic [ROB_W-1:0] c_tag [NCOMMIT];
  logic [XLEN-1:0]  c_val [NCOMMIT];

  for (genvar k = 0; k < NCOMMIT; k++) begin : g_cm
    assign c_rd[k]  = cm_rd[k*REG_W +: REG_W];
    assign c_tag[k] = cm_robpos[k*ROB_W +: ROB_W];
    assign c_val[k] = cm_val[k*XLEN +: XLEN];
  end

  // Reads see pre-edge state; a busy source whose producer commits this cycle is bypassed.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [REG_W-1:0] r;
    logic             hit;
    logic [XLEN-1:0]  byp;

    assign r = rd_pos[p*REG_W +: REG_W];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int k = 0; k < NCOMMIT; k++) begin
        if (cm_valid[k] && c_tag[k] == qi_q[r]) begin
          hit = 1'b1;
          byp = c_val[k];
        end
      end
    end

    assign rd_flag[p] = rd_query[p];
    assign rd_type[p] = rd_query[p] && busy_q[r] && !hit;
    assign rd_val[p*XLEN +: XLEN] = !rd_query[p] ? '0 :
                                    !busy_q[r]   ? val_q[r] :
                                    hit          ? byp : XLEN'(qi_q[r]);
  end

  logic [XLEN-1:0]  val_d [NREG];
  logic [NREG-1:0]  busy_cm;
  logic [NREG-1:0]  busy_d;
  logic [ROB_W-1:0] qi_d [NREG];
  logic [NREG-1:0]  snap_busy_cm [NCKPT];

  // Commits: highest port wins the value; busy drops only when the retiring tag is still current.
  always_comb begin
    for (int i = 0; i < NREG; i++) val_d[i] = val_q[i];
    busy_cm = busy_q;
    for (int k = 0; k < NCOMMIT; k++) begin
      if (cm_valid[k] && c_rd[k] != '0) begin
        val_d[c_rd[k]] = c_val[k];
        if (qi_q[c_rd[k]] == c_tag[k]) busy_cm[c_rd[k]] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_d = busy_cm;
    for (int i = 0; i < NREG; i++) qi_d[i] = qi_q[i];
    if (lock && lock_rd != '0) begin
      busy_d[lock_rd] = 1'b1;
      qi_d[lock_rd]   = lock_robpos;
    end
  end

  // Snapshots retire tags alongside the live state so a restore cannot revive a committed producer.
  always_comb begin
    for (int s = 0; s < NCKPT; s++) begin
      snap_busy_cm[s] = snap_busy_q[s];
      for (int k = 0; k < NCOMMIT; k++) begin
        if (cm_valid[k] && c_rd[k] != '0 && snap_qi_q[s][c_rd[k]] == c_tag[k])
          snap_busy_cm[s][c_rd[k]] = 1'b0;
      end
    end
  end

  logic            save_ok, rel_ok;
  logic [CK_W-1:0] restore_cnt;

  assign ckpt_full   = (count_q == CNT_W'(NCKPT));
  assign ckpt_id     = tail_q;
  assign save_ok     = ckpt_save && !ckpt_full;
  assign rel_ok      = ckpt_release && (count_q != '0);
  assign restore_cnt = ckpt_restore_id - head_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        qi_q[i]  <= '0;
      end
      busy_q <= '0;
      for (int s = 0; s < NCKPT; s++) begin
        snap_busy_q[s] <= '0;
        for (int i = 0; i < NREG; i++) snap_qi_q[s][i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= val_d[i];
        qi_q[i]  <= '0;
      end
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (ready) begin
      for (int i = 0; i < NREG; i++) val_q[i] <= val_d[i];
      for (int s = 0; s < NCKPT; s++) snap_busy_q[s] <= snap_busy_cm[s];
      if (ckpt_restore) begin
        busy_q <= snap_busy_cm[ckpt_restore_id];
        for (int i = 0; i < NREG; i++) qi_q[i] <= snap_qi_q[ckpt_restore_id][i];
        tail_q  <= ckpt_restore_id;
        count_q <= {1'b0, restore_cnt};
      end else begin
        busy_q <= busy_d;
        for (int i = 0; i < NREG; i++) qi_q[i] <= qi_d[i];
        if (save_ok) begin
          snap_busy_q[tail_q] <= busy_d;
          for (int i = 0; i < NREG; i++) snap_qi_q[tail_q][i] <= qi_d[i];
        end
        tail_q  <= tail_q + CK_W'(save_ok);
        head_q  <= head_q + CK_W'(rel_ok);
        count_q <= count_q + CNT_W'(save_ok) - CNT_W'(rel_ok);
      end
    end
  end

endmodule
